uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with a configurable frame format (5–9 data bits, none/even/odd parity, 1 or 2 stop bits) and a runtime baud divisor. It adds mid-bit sampling with false-start rejection, framing/parity/break detection and an overrun flag. Received frames go into a small synchronous FIFO and are drained through a ready/valid interface. It sits between the pad-side `rx` line and the register/bus logic that formerly polled a single-byte receiver.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `DIV_WIDTH`, 13: width of the baud divisor.
- `DEFAULT_DIV`, 13'h1869: divisor loaded at reset, in clk cycles per bit.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, at least 2.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `rx` in 1: serial input, asynchronous, idle high.
- `speed` in DIV_WIDTH: new divisor.
- `set_speed` in 1: load `speed` into the divisor register.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 treated as none.
- `stop2` in 1: expect two stop bits.
- `rx_data` out DATA_BITS: FIFO head data.
- `rx_frame_err` out 1: head entry had a bad stop bit.
- `rx_parity_err` out 1: head entry had a bad parity bit.
- `rx_break` out 1: head entry is a break.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: consumer accepts the head entry.
- `rx_level` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `overrun` out 1: sticky; a frame was dropped because the FIFO was full.
- `clear_overrun` in 1: clears `overrun`.
- `busy` out 1: FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser preset to 1. All logic uses the synchronised `rxs`.
- Effective divisor `div` = max(divisor register, 4). Bit period = `div` clk cycles. Counter width is DIV_WIDTH.
- `set_speed` has priority over the FSM:
  - loads the divisor;
  - aborts any frame in progress and returns to IDLE, discarding partial data;
  - leaves the FIFO and `overrun` untouched.
- FSM states:
  - IDLE: when `rxs`=0, go to START with counter cleared.
  - START: wait floor(div/2) cycles, then sample. If `rxs`=1 it is a false start: go to IDLE, nothing pushed. Otherwise go to DATA.
  - DATA: sample every `div` cycles, LSB first, into a shift register. After DATA_BITS samples, go to PARITY if parity is enabled, else STOP.
  - PARITY: sample once. `parity_err` = sampled bit differs from the XOR of the data (even mode) or its inverse (odd mode).
  - STOP: sample once.
    - If the stop bit is 1 and `stop2`=1, go to STOP2.
    - Otherwise push {break, frame_err, parity_err, data} and go to IDLE. If the stop bit was 0, go to BRK_WAIT instead of IDLE.
  - STOP2: sample once. A 0 sets frame_err. Push the entry, then go to IDLE, or to BRK_WAIT if the sample was 0.
  - BRK_WAIT: stay until `rxs`=1, then go to IDLE.
- Break = all data bits 0, parity bit 0 if present, and first stop bit 0. A break implies frame_err.
- FIFO behaviour:
  - A pop occurs when `rx_valid`&&`rx_ready`.
  - A push into a full FIFO with no pop in the same cycle drops the new frame and sets `overrun`.
  - Push into a full FIFO with a pop in the same cycle: both succeed, level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - `clear_overrun` in the same cycle as a new overrun: the flag stays set.

## Timing
- Reset values: `rx_data`=0, all error flags 0, `rx_valid`=0, `rx_level`=0, `overrun`=0, `busy`=0. FSM in IDLE, divisor = DEFAULT_DIV, synchroniser = 1.
- Reset mid-frame discards the frame and empties the FIFO.
- Start detect: 2 cycles after `rx` falls (synchroniser delay).
- First data sample: floor(div/2)+div cycles after start detect; each later sample follows `div` cycles after the previous one.
- The push happens in the cycle of the final stop sample. `rx_valid` and `rx_level` update on the next edge.
- Pop is combinational on the head. The next entry appears on the edge after the pop.
- `rx_valid` may stay high across back-to-back pops.
- The FSM returns to IDLE one cycle after the last stop sample. It therefore resyncs on a start bit that immediately follows, with no idle gap required.

## Structure
- Shared package/header `uart_pkg`:
  - FSM state encodings (IDLE, START, DATA, PARITY, STOP, STOP2, BRK_WAIT);
  - parity-mode codes;
  - DEFAULT_DIV;
  - minimum-divisor constant 4.
- Sub-module `uart_rx_fifo_mem`: a synchronous FIFO parameterised by WIDTH (DATA_BITS+3) and DEPTH. It provides full/empty, level and same-cycle push/pop.
- The FSM, counter, shifter and synchroniser stay in the top level.

## Test plan
- div=16, 8N1, send 0xA5 → one entry: `rx_data`=0xA5, all flags 0. `rx_valid` rises 1 cycle after the stop sample.
- div=16, 8E1, send 0x03 with parity bit 1 → `rx_data`=0x03, `rx_parity_err`=1. Same frame with parity 0 → `rx_parity_err`=0.
- 8N2, second stop bit driven 0 → `rx_frame_err`=1. Then `rx` held low for 20 bit times → one entry with `rx_break`=1, `busy`=1 until `rx` returns high, and no further entries.
- FIFO_DEPTH=4, `rx_ready`=0, send 0x11..0x55 → `rx_level`=4, `overrun`=1, pops return 0x11..0x44. `clear_overrun` → `overrun`=0.
- `rx` low pulse of 3 cycles with div=16 → false start, no entry, `busy` returns to 0.
- `set_speed` with `speed`=8 mid-frame → frame aborted, no entry; next 0x5A at div=8 received correctly.
- `reset` asserted during DATA → all outputs at reset values immediately, divisor = 13'h1869.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM encodings,
// parity-mode codes and divisor limits.
package uart_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;
    localparam logic [2:0] ST_STOP2    = 3'd5;
    localparam logic [2:0] ST_BRK_WAIT = 3'd6;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int UART_DEFAULT_DIV = 13'h1869;
    localparam int MIN_DIV          = 4;

    function automatic logic parity_enabled(input logic [1:0] mode);
        logic en;
        en = 1'b0;
        unique case (1'b1)
            mode == PAR_EVEN: en = 1'b1;
            mode == PAR_ODD:  en = 1'b1;
            default:          en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Small synchronous FIFO with same-cycle push/pop and a
// combinational head; the head reads as zero while empty.
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap on overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, parity/framing/break
// detection and a ready/valid receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int DIV_WIDTH   = 13,
    parameter int DEFAULT_DIV = UART_DEFAULT_DIV,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic [DIV_WIDTH-1:0]          speed,
    input  logic                          set_speed,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_break,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          overrun,
    input  logic                          clear_overrun,
    output logic                          busy
);

    localparam int EW = DATA_BITS + 3;

    logic                 sync1;
    logic                 rxs;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] div;
    logic [DIV_WIDTH-1:0] cnt;
    logic [2:0]           state;
    logic [3:0]           bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 par_err;
    logic                 half_hit;
    logic                 bit_hit;
    logic                 par_exp;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 brk;
    logic [EW-1:0]        wdata;
    logic [EW-1:0]        rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    assign div      = (div_reg < DIV_WIDTH'(MIN_DIV)) ?
                      DIV_WIDTH'(MIN_DIV) : div_reg;
    assign half_hit = cnt == (div >> 1) - DIV_WIDTH'(1);
    assign bit_hit  = cnt == div - DIV_WIDTH'(1);
    assign par_exp  = (^shreg) ^ (parity_mode == PAR_ODD);

    // A break needs an all-zero frame up to and including stop 1.
    assign brk   = (state == ST_STOP) && !rxs && (shreg == '0) && !par_bit;
    assign wdata = {brk, !rxs, par_err, shreg};
    assign push  = bit_hit && !set_speed &&
                   (((state == ST_STOP) && !(rxs && stop2)) ||
                    (state == ST_STOP2));
    assign pop   = rx_valid && rx_ready;
    assign busy  = state != ST_IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg <= DIV_WIDTH'(DEFAULT_DIV);
            state   <= ST_IDLE;
            cnt     <= '0;
            bcnt    <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            par_err <= 1'b0;
        end else if (set_speed) begin
            div_reg <= speed;
            state   <= ST_IDLE;
            cnt     <= '0;
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
            unique case (state)
                ST_IDLE: begin
                    cnt     <= '0;
                    par_bit <= 1'b0;
                    par_err <= 1'b0;
                    if (!rxs) state <= ST_START;
                end
                ST_START: begin
                    if (half_hit) begin
                        cnt   <= '0;
                        bcnt  <= '0;
                        state <= rxs ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_hit) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        bcnt  <= bcnt + 4'd1;
                        if (bcnt == 4'(DATA_BITS - 1)) begin
                            state <= parity_enabled(parity_mode) ?
                                     ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_hit) begin
                        cnt     <= '0;
                        par_bit <= rxs;
                        par_err <= rxs != par_exp;
                        state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_hit) begin
                        cnt <= '0;
                        if (rxs && stop2) state <= ST_STOP2;
                        else state <= rxs ? ST_IDLE : ST_BRK_WAIT;
                    end
                end
                ST_STOP2: begin
                    if (bit_hit) begin
                        cnt   <= '0;
                        state <= rxs ? ST_IDLE : ST_BRK_WAIT;
                    end
                end
                ST_BRK_WAIT: begin
                    cnt <= '0;
                    if (rxs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A new drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (push && full && !pop) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

    uart_rx_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (rx_level)
    );

    assign rx_valid      = !empty;
    assign rx_break      = rdata[EW-1];
    assign rx_frame_err  = rdata[EW-2];
    assign rx_parity_err = rdata[EW-3];
    assign rx_data       = rdata[DATA_BITS-1:0];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised scoreboard bench for uart_rx_fifo with a
// frame-level reference model.
module tb_uart_rx_fifo;

    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [12:0] speed;
    logic        set_speed;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic [7:0]  rx_data;
    logic        rx_frame_err;
    logic        rx_parity_err;
    logic        rx_break;
    logic        rx_valid;
    logic        rx_ready;
    logic [2:0]  rx_level;
    logic        overrun;
    logic        clear_overrun;
    logic        busy;

    int tests = 0;
    int fails = 0;
    bit rdy_rand = 0;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .speed         (speed),
        .set_speed     (set_speed),
        .parity_mode   (parity_mode),
        .stop2         (stop2),
        .rx_data       (rx_data),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_break      (rx_break),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_level      (rx_level),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    // Expected entry {break, frame_err, parity_err, data} from frame contents.
    function automatic logic [10:0] model(input logic [7:0] d,
        input logic [1:0] pm, input logic pb, input logic s1,
        input logic st2, input logic s2);
        int  ones;
        bit  pen;
        bit  perr;
        bit  brk;
        bit  frm;
        ones = $countones(d);
        pen  = (pm == 2'd1) || (pm == 2'd2);
        perr = 0;
        if (pm == 2'd1) perr = (pb != (ones % 2));
        if (pm == 2'd2) perr = (pb != (1 - ones % 2));
        brk  = (d == 0) && (!pen || !pb) && !s1;
        frm  = !s1 || (st2 && !s2);
        return {brk, frm, perr, d};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm,
        input logic pb, input logic s1, input logic st2, input logic s2,
        input int div);
        logic q[$];
        q.push_back(1'b0);
        for (int i = 0; i < DB; i++) q.push_back(d[i]);
        if (pm == 2'd1 || pm == 2'd2) q.push_back(pb);
        q.push_back(s1);
        if (st2) q.push_back(s2);
        @(posedge clk);
        foreach (q[i]) begin
            #1 rx = q[i];
            repeat (div) @(posedge clk);
        end
        #1 rx = 1'b1;
        if (!s1 || (st2 && !s2)) repeat (div) @(posedge clk);
    endtask

    task automatic xfer(input logic [7:0] d, input logic [1:0] pm,
        input logic pb, input logic s1, input logic st2, input logic s2,
        input int div, input bit expect_push);
        if (expect_push) exp_q.push_back(model(d, pm, pb, s1, st2, s2));
        parity_mode = pm;
        stop2 = st2;
        send_frame(d, pm, pb, s1, st2, s2, div);
    endtask

    task automatic load_speed(input logic [12:0] v);
        @(posedge clk);
        #1 speed = v;
        set_speed = 1'b1;
        @(posedge clk);
        #1 set_speed = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        logic [10:0] got;
        logic [10:0] want;
        if (!reset && rx_valid && rx_ready) begin
            got = {rx_break, rx_frame_err, rx_parity_err, rx_data};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_entry got=%h expected=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    fails++;
                    $display("FAIL entry got=%h expected=%h", got, want);
                end
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1 if (rdy_rand) rx_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        speed = '0;
        set_speed = 1'b0;
        parity_mode = 2'd0;
        stop2 = 1'b0;
        rx_ready = 1'b0;
        clear_overrun = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_level", rx_level, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_flags", {rx_break, rx_frame_err, rx_parity_err}, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);

        // 8N1 0xA5 with push-latency check
        load_speed(13'd16);
        fork
            xfer(8'hA5, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16, 1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 chk("a5_valid_before", rx_valid, 0);
                @(posedge clk);
                #1 chk("a5_valid_after", rx_valid, 1);
            end
        join
        chk("a5_level", rx_level, 1);
        chk("a5_head", rx_data, 8'hA5);
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("a5_drained", rx_valid, 0);

        // 8E1 parity error / parity ok
        xfer(8'h03, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 16, 1);
        xfer(8'h03, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 16, 1);

        // 8N2 bad second stop, then a long break
        xfer(8'h3C, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16, 1);
        exp_q.push_back(model(8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (320) @(posedge clk);
        #1 chk("brk_busy", busy, 1);
        rx = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("brk_idle", busy, 0);
        chk("brk_level", rx_level, 0);

        // Overrun: five frames into a four-deep FIFO
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            xfer(8'(i * 17), 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16, i <= 4);
        end
        repeat (2) @(posedge clk);
        #1 chk("ovr_level", rx_level, 4);
        chk("ovr_flag", overrun, 1);
        rx_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1 chk("ovr_drained", rx_level, 0);
        chk("ovr_sticky", overrun, 1);
        clear_overrun = 1'b1;
        @(posedge clk);
        #1 clear_overrun = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // False start: 3-cycle low pulse
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("fs_busy", busy, 1);
        repeat (30) @(posedge clk);
        #1 chk("fs_idle", busy, 0);
        chk("fs_level", rx_level, 0);

        // set_speed mid-frame aborts, then 0x5A at div 8
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (16) @(posedge clk);
        #1 rx = 1'b1;
        repeat (32) @(posedge clk);
        #1 chk("abort_busy", busy, 1);
        speed = 13'd8;
        set_speed = 1'b1;
        @(posedge clk);
        #1 set_speed = 1'b0;
        repeat (30) @(posedge clk);
        #1 chk("abort_idle", busy, 0);
        chk("abort_level", rx_level, 0);
        xfer(8'h5A, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8, 1);

        // Randomised frames with random consumer back-pressure
        rdy_rand = 1;
        for (int f = 0; f < 40; f++) begin
            int          div;
            logic [7:0]  d;
            if (f % 10 == 0) begin
                div = (f / 10 == 1) ? 11 : (f / 10 == 2) ? 16 : 8;
                load_speed(13'(div));
            end
            d = 8'($urandom);
            if ($urandom_range(0, 9) == 0) d = 8'h00;
            xfer(d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) != 0, div, 1);
        end
        rdy_rand = 0;
        rx_ready = 1'b1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        #1 chk("queue_drained", exp_q.size(), 0);
        chk("rand_overrun", overrun, 0);

        // Reset during DATA
        rx_ready = 1'b0;
        xfer(8'h12, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16, 0);
        @(posedge clk);
        #1 chk("pre_rst_level", rx_level, 1);
        rx = 1'b0;
        repeat (48) @(posedge clk);
        #1 chk("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_level", rx_level, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", rx_data, 0);
        rx = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        rx_ready = 1'b1;
        // A 16-cycle low only looks like a start at the 0x1869 divisor
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (16) @(posedge clk);
        #1 rx = 1'b1;
        repeat (184) @(posedge clk);
        #1 chk("defdiv_busy", busy, 1);
        repeat (3000) @(posedge clk);
        #1 chk("defdiv_idle", busy, 0);
        chk("defdiv_level", rx_level, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
